// File: rtl/rfphoenix_branch_resolve.sv
// Branch resolution unit: compares the evaluated branch outcome with the
// fetch-time prediction, raises a held redirect on mispredict, pulses a
// predictor update for every resolved branch and keeps saturating
// branch/mispredict counters.
module rfphoenix_branch_resolve #(
    parameter int unsigned AW         = 32,
    parameter int unsigned INSN_BYTES = 5,
    parameter int unsigned CNTW       = 32
) (
    input  logic            rst_n,
    input  logic            clk,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [AW-1:0]   br_pc_i,
    input  logic [AW-1:0]   br_tgt_i,
    input  logic            br_taken_i,
    input  logic            pred_taken_i,
    input  logic [AW-1:0]   pred_tgt_i,
    input  logic            kill_i,
    output logic            redir_valid_o,
    output logic [AW-1:0]   redir_pc_o,
    input  logic            redir_ack_i,
    output logic            upd_valid_o,
    output logic [AW-1:0]   upd_pc_o,
    output logic            upd_taken_o,
    output logic [AW-1:0]   upd_tgt_o,
    output logic [CNTW-1:0] br_cnt_o,
    output logic [CNTW-1:0] mis_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured branch
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   tgt_q, tgt_d;
    logic            taken_q, taken_d;
    logic            ptaken_q, ptaken_d;
    logic [AW-1:0]   ptgt_q, ptgt_d;

    // Output registers
    logic            redir_valid_q, redir_valid_d;
    logic [AW-1:0]   redir_pc_q, redir_pc_d;
    logic            upd_valid_q, upd_valid_d;
    logic [AW-1:0]   upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;
    logic [AW-1:0]   upd_tgt_q, upd_tgt_d;
    logic [CNTW-1:0] br_cnt_q, br_cnt_d;
    logic [CNTW-1:0] mis_cnt_q, mis_cnt_d;

    logic            capture;
    logic            mis;
    logic [AW-1:0]   actual_pc;

    // Resolution math on the captured branch
    always_comb begin
        actual_pc = taken_q ? tgt_q : (pc_q + AW'(INSN_BYTES));
        mis       = (taken_q != ptaken_q) || (taken_q && ptaken_q && (ptgt_q != tgt_q));
        capture   = (state_q == S_IDLE) && br_valid_i && !kill_i;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill returns to IDLE from any state
    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (br_valid_i) state_d = S_EVAL;
                S_EVAL:  state_d = mis ? S_REDIR : S_IDLE;
                S_REDIR: if (redir_ack_i && redir_valid_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        br_ready_o    = (state_q == S_IDLE);
        redir_valid_o = redir_valid_q;
        redir_pc_o    = redir_pc_q;
        upd_valid_o   = upd_valid_q;
        upd_pc_o      = upd_pc_q;
        upd_taken_o   = upd_taken_q;
        upd_tgt_o     = upd_tgt_q;
        br_cnt_o      = br_cnt_q;
        mis_cnt_o     = mis_cnt_q;
    end

    // Datapath next values: capture, resolve, redirect handshake, counters
    always_comb begin
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        taken_d       = taken_q;
        ptaken_d      = ptaken_q;
        ptgt_d        = ptgt_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_tgt_d     = upd_tgt_q;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;

        if (capture) begin
            pc_d     = br_pc_i;
            tgt_d    = br_tgt_i;
            taken_d  = br_taken_i;
            ptaken_d = pred_taken_i;
            ptgt_d   = pred_tgt_i;
        end

        if (!kill_i) begin
            if (state_q == S_EVAL) begin
                upd_valid_d = 1'b1;
                upd_pc_d    = pc_q;
                upd_taken_d = taken_q;
                upd_tgt_d   = tgt_q;
                br_cnt_d    = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + CNTW'(1);
                if (mis) begin
                    mis_cnt_d     = (mis_cnt_q == '1) ? mis_cnt_q : mis_cnt_q + CNTW'(1);
                    redir_pc_d    = actual_pc;
                    redir_valid_d = 1'b1;
                end
            end else if (state_q == S_REDIR && redir_ack_i && redir_valid_q) begin
                redir_valid_d = 1'b0;
            end
        end else begin
            redir_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            tgt_q         <= '0;
            taken_q       <= 1'b0;
            ptaken_q      <= 1'b0;
            ptgt_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_tgt_q     <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            taken_q       <= taken_d;
            ptaken_q      <= ptaken_d;
            ptgt_q        <= ptgt_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_tgt_q     <= upd_tgt_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_rfphoenix_branch_resolve.sv
// Directed bench for rfphoenix_branch_resolve. A second instance with
// 2-bit counters shares all inputs so counter saturation is reachable.
module tb_rfphoenix_branch_resolve;

    localparam int unsigned AW = 32;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_valid_i = 1'b0;
    logic [AW-1:0] br_pc_i = '0;
    logic [AW-1:0] br_tgt_i = '0;
    logic          br_taken_i = 1'b0;
    logic          pred_taken_i = 1'b0;
    logic [AW-1:0] pred_tgt_i = '0;
    logic          kill_i = 1'b0;
    logic          redir_ack_i = 1'b0;

    logic          br_ready_o, redir_valid_o, upd_valid_o, upd_taken_o;
    logic [AW-1:0] redir_pc_o, upd_pc_o, upd_tgt_o;
    logic [31:0]   br_cnt_o, mis_cnt_o;

    logic          s_br_ready_o, s_redir_valid_o, s_upd_valid_o, s_upd_taken_o;
    logic [AW-1:0] s_redir_pc_o, s_upd_pc_o, s_upd_tgt_o;
    logic [SW-1:0] s_br_cnt_o, s_mis_cnt_o;

    rfphoenix_branch_resolve #(.AW(AW), .INSN_BYTES(5), .CNTW(32)) dut (
        .rst_n(rst_n), .clk(clk),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
        .br_pc_i(br_pc_i), .br_tgt_i(br_tgt_i), .br_taken_i(br_taken_i),
        .pred_taken_i(pred_taken_i), .pred_tgt_i(pred_tgt_i), .kill_i(kill_i),
        .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o), .redir_ack_i(redir_ack_i),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
        .upd_tgt_o(upd_tgt_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
    );

    rfphoenix_branch_resolve #(.AW(AW), .INSN_BYTES(5), .CNTW(SW)) dut_sat (
        .rst_n(rst_n), .clk(clk),
        .br_valid_i(br_valid_i), .br_ready_o(s_br_ready_o),
        .br_pc_i(br_pc_i), .br_tgt_i(br_tgt_i), .br_taken_i(br_taken_i),
        .pred_taken_i(pred_taken_i), .pred_tgt_i(pred_tgt_i), .kill_i(kill_i),
        .redir_valid_o(s_redir_valid_o), .redir_pc_o(s_redir_pc_o), .redir_ack_i(redir_ack_i),
        .upd_valid_o(s_upd_valid_o), .upd_pc_o(s_upd_pc_o), .upd_taken_o(s_upd_taken_o),
        .upd_tgt_o(s_upd_tgt_o), .br_cnt_o(s_br_cnt_o), .mis_cnt_o(s_mis_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] tgt;
        logic          mis;
        logic [AW-1:0] rpc;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned m_br   = 0;
    int unsigned m_mis  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned c);
        return (c > 3) ? 3 : c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a branch with br_valid_i=1; optionally record its expected outcome
    task automatic present(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                           input logic taken, input logic ptaken,
                           input logic [AW-1:0] ptgt, input bit push);
        exp_t e;
        br_pc_i      = pc;
        br_tgt_i     = tgt;
        br_taken_i   = taken;
        pred_taken_i = ptaken;
        pred_tgt_i   = ptgt;
        br_valid_i   = 1'b1;
        e.pc    = pc;
        e.taken = taken;
        e.tgt   = tgt;
        e.rpc   = taken ? tgt : pc + 32'd5;
        e.mis   = (taken != ptaken) || (taken && ptaken && (ptgt != tgt));
        if (push) sbq.push_back(e);
    endtask

    // Cycle after capture: busy, no result yet
    task automatic eval_cycle(input string tag);
        chk({tag, " eval_ready"}, 64'(br_ready_o), 64'd0);
        chk({tag, " eval_upd"}, 64'(upd_valid_o), 64'd0);
        chk({tag, " eval_redir"}, 64'(redir_valid_o), 64'd0);
    endtask

    // Result cycle: pop the scoreboard and compare
    task automatic expect_resolve(input string tag);
        exp_t e;
        chk({tag, " upd_valid"}, 64'(upd_valid_o), 64'd1);
        chk({tag, " sb_size"}, 64'(sbq.size()), 64'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            m_br++;
            if (e.mis) m_mis++;
            chk({tag, " upd_pc"}, 64'(upd_pc_o), 64'(e.pc));
            chk({tag, " upd_taken"}, 64'(upd_taken_o), 64'(e.taken));
            if (e.taken) chk({tag, " upd_tgt"}, 64'(upd_tgt_o), 64'(e.tgt));
            chk({tag, " redir_valid"}, 64'(redir_valid_o), 64'(e.mis));
            if (e.mis) chk({tag, " redir_pc"}, 64'(redir_pc_o), 64'(e.rpc));
            chk({tag, " br_ready"}, 64'(br_ready_o), 64'(!e.mis));
        end
        chk({tag, " br_cnt"}, 64'(br_cnt_o), 64'(m_br));
        chk({tag, " mis_cnt"}, 64'(mis_cnt_o), 64'(m_mis));
        chk({tag, " sat_br_cnt"}, 64'(s_br_cnt_o), 64'(sat(m_br)));
        chk({tag, " sat_mis_cnt"}, 64'(s_mis_cnt_o), 64'(sat(m_mis)));
    endtask

    // Hold redirect for n cycles without ack, then ack and see it drop
    task automatic redir_hold(input string tag, input logic [AW-1:0] rpc, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, " hold_valid"}, 64'(redir_valid_o), 64'd1);
            chk({tag, " hold_pc"}, 64'(redir_pc_o), 64'(rpc));
            chk({tag, " hold_ready"}, 64'(br_ready_o), 64'd0);
        end
        redir_ack_i = 1'b1;
        tick();
        redir_ack_i = 1'b0;
        chk({tag, " ack_valid"}, 64'(redir_valid_o), 64'd0);
        chk({tag, " ack_ready"}, 64'(br_ready_o), 64'd1);
    endtask

    // Full flow for one branch presented in IDLE
    task automatic run_branch(input string tag, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                              input logic taken, input logic ptaken, input logic [AW-1:0] ptgt);
        present(pc, tgt, taken, ptaken, ptgt, 1'b1);
        tick();
        br_valid_i = 1'b0;
        eval_cycle(tag);
        tick();
        expect_resolve(tag);
    endtask

    initial begin
        // Reset with random inputs
        br_valid_i   = 1'($urandom);
        br_pc_i      = $urandom;
        br_tgt_i     = $urandom;
        br_taken_i   = 1'($urandom);
        pred_taken_i = 1'($urandom);
        pred_tgt_i   = $urandom;
        redir_ack_i  = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst br_ready", 64'(br_ready_o), 64'd1);
        chk("rst redir_valid", 64'(redir_valid_o), 64'd0);
        chk("rst redir_pc", 64'(redir_pc_o), 64'd0);
        chk("rst upd_valid", 64'(upd_valid_o), 64'd0);
        chk("rst upd_pc", 64'(upd_pc_o), 64'd0);
        chk("rst upd_taken", 64'(upd_taken_o), 64'd0);
        chk("rst upd_tgt", 64'(upd_tgt_o), 64'd0);
        chk("rst br_cnt", 64'(br_cnt_o), 64'd0);
        chk("rst mis_cnt", 64'(mis_cnt_o), 64'd0);
        br_valid_i  = 1'b0;
        redir_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Correct not-taken
        run_branch("nt", 32'h100, 32'h180, 1'b0, 1'b0, 32'h0);
        tick();
        chk("nt pulse_width", 64'(upd_valid_o), 64'd0);
        chk("nt idle_ready", 64'(br_ready_o), 64'd1);

        // Direction mispredict, ack held low 3 cycles
        run_branch("mis", 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
        redir_hold("mis", 32'h200, 3);

        // Ack with no redirect pending is ignored
        redir_ack_i = 1'b1;
        tick();
        redir_ack_i = 1'b0;
        chk("stray_ack redir_valid", 64'(redir_valid_o), 64'd0);
        chk("stray_ack ready", 64'(br_ready_o), 64'd1);

        // Predicted taken but not taken; fall-through wraps
        run_branch("wrap", 32'hFFFF_FFFE, 32'h40, 1'b0, 1'b1, 32'h500);
        redir_hold("wrap", 32'h0000_0003, 1);

        // Wrong target
        run_branch("tgt", 32'h1000, 32'h200, 1'b1, 1'b1, 32'h300);
        redir_hold("tgt", 32'h200, 1);

        // Correct taken with matching target
        run_branch("tk", 32'h2000, 32'h2400, 1'b1, 1'b1, 32'h2400);
        tick();

        // Kill in EVAL suppresses the update and counts
        present(32'h3000, 32'h3800, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        br_valid_i = 1'b0;
        eval_cycle("kill_eval");
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kill_eval upd", 64'(upd_valid_o), 64'd0);
        chk("kill_eval redir", 64'(redir_valid_o), 64'd0);
        chk("kill_eval ready", 64'(br_ready_o), 64'd1);
        chk("kill_eval br_cnt", 64'(br_cnt_o), 64'(m_br));
        chk("kill_eval mis_cnt", 64'(mis_cnt_o), 64'(m_mis));

        // Kill in IDLE drops a simultaneous capture
        present(32'h3100, 32'h3200, 1'b1, 1'b0, 32'h0, 1'b0);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        br_valid_i = 1'b0;
        chk("kill_idle ready", 64'(br_ready_o), 64'd1);
        tick();
        chk("kill_idle upd", 64'(upd_valid_o), 64'd0);
        chk("kill_idle br_cnt", 64'(br_cnt_o), 64'(m_br));

        // Kill and ack together in REDIR
        run_branch("kill_redir", 32'h4000, 32'h4800, 1'b1, 1'b0, 32'h0);
        kill_i = 1'b1;
        redir_ack_i = 1'b1;
        tick();
        kill_i = 1'b0;
        redir_ack_i = 1'b0;
        chk("kill_redir valid", 64'(redir_valid_o), 64'd0);
        chk("kill_redir ready", 64'(br_ready_o), 64'd1);
        run_branch("after_kill", 32'h4100, 32'h4200, 1'b0, 1'b0, 32'h0);
        tick();

        // Back-pressure: br_valid_i held while busy, captured once
        present(32'h5000, 32'h5500, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        eval_cycle("bp");
        tick();
        expect_resolve("bp");
        tick();
        tick();
        chk("bp busy_ready", 64'(br_ready_o), 64'd0);
        chk("bp busy_redir", 64'(redir_valid_o), 64'd1);
        redir_ack_i = 1'b1;
        br_valid_i = 1'b0;
        tick();
        redir_ack_i = 1'b0;
        chk("bp ack_valid", 64'(redir_valid_o), 64'd0);
        tick();
        tick();
        chk("bp no_second_upd", 64'(upd_valid_o), 64'd0);
        chk("bp br_cnt_once", 64'(br_cnt_o), 64'(m_br));
        chk("sat br_cnt_max", 64'(s_br_cnt_o), 64'h3);
        chk("sat mis_cnt_max", 64'(s_mis_cnt_o), 64'h3);

        // Asynchronous reset while in REDIR
        run_branch("arst", 32'h6000, 32'h6600, 1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst redir_valid", 64'(redir_valid_o), 64'd0);
        chk("arst redir_pc", 64'(redir_pc_o), 64'd0);
        chk("arst upd_valid", 64'(upd_valid_o), 64'd0);
        chk("arst ready", 64'(br_ready_o), 64'd1);
        chk("arst br_cnt", 64'(br_cnt_o), 64'd0);
        chk("arst mis_cnt", 64'(mis_cnt_o), 64'd0);
        m_br  = 0;
        m_mis = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_branch("post_rst", 32'h7000, 32'h7700, 1'b0, 1'b0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
